// File: rtl/mag_pkg.sv
// -----------------------------------------------------------------------------
// mag_pkg
//   Shared types and default constants for the magnetron power controller.
//   - state_e      : controller state encoding
//   - MAG_N_LEVELS : default number of duty slots per power period
//   - MAG_SLOT_TICKS : default clock cycles per duty slot
//   - MAG_LEVEL_W  : default width of the power level field
// -----------------------------------------------------------------------------
package mag_pkg;

    localparam int MAG_N_LEVELS   = 10;
    localparam int MAG_SLOT_TICKS = 100;
    localparam int MAG_LEVEL_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COOK   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mag_duty_gen.sv
// -----------------------------------------------------------------------------
// mag_duty_gen
//   Slot-based duty cycle generator for the COOK state. A power period is
//   N_LEVELS slots of SLOT_TICKS clocks; the drive is on while the slot index
//   is below the requested level.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     clear      : restart counters at slot 0 / tick 0 on this edge
//     enable     : advance counters on this edge (ignored when clear is high)
//     level      : duty level applied to the next-cycle slot
//     on_next    : drive request for the cycle following this edge
// -----------------------------------------------------------------------------
module mag_duty_gen #(
    parameter int N_LEVELS   = 10,
    parameter int SLOT_TICKS = 100,
    parameter int LEVEL_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] level,
    output logic               on_next
);

    localparam int TICK_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int SLOT_W = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SLOT_TICKS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_LEVELS - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        tick_d = tick_q;
        slot_d = slot_q;
        if (clear) begin
            tick_d = '0;
            slot_d = '0;
        end else if (enable) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // Compare against the slot the next cycle will be in, so the registered
    // drive lines up with the counters (first on-cycle is the entry edge).
    assign on_next = (32'(slot_d) < 32'(level));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
            slot_q <= '0;
        end else begin
            tick_q <= tick_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/mag_power_ctrl.sv
// -----------------------------------------------------------------------------
// mag_power_ctrl
//   Magnetron controller with IDLE/COOK/PAUSED/DONE states, slot-based duty
//   cycling for power levels and a combinational door interlock.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     startn        : start button, active low, falling-edge detected
//     stopn         : stop/pause button, active low, level
//     clearn        : clear button, active low, level
//     door_closed   : 1 = door closed
//     timer_done    : 1 = cook timer expired
//     power_level   : requested level, sampled when a start is accepted
//     mag_on        : magnetron drive (registered, gated by door_closed)
//     cooking/paused/done : state decodes
//     active_level  : level latched at the last accepted start
// -----------------------------------------------------------------------------
module mag_power_ctrl
    import mag_pkg::*;
#(
    parameter int N_LEVELS   = MAG_N_LEVELS,
    parameter int SLOT_TICKS = MAG_SLOT_TICKS,
    parameter int LEVEL_W    = MAG_LEVEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               timer_done,
    input  logic [LEVEL_W-1:0] power_level,
    output logic               mag_on,
    output logic               cooking,
    output logic               paused,
    output logic               done,
    output logic [LEVEL_W-1:0] active_level
);

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(N_LEVELS);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               startn_q, startn_d;
    logic               mag_q, mag_d;

    logic               start_edge;
    logic               start_ok;
    logic [LEVEL_W-1:0] level_clamped;
    logic               cook_entry;
    logic               cook_hold;
    logic               duty_on;

    assign start_edge    = startn_q & ~startn;
    assign start_ok      = start_edge & door_closed & ~timer_done & (power_level != '0);
    assign level_clamped = (power_level > LEVEL_MAX) ? LEVEL_MAX : power_level;
    assign startn_d      = startn;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                // stop and clear both outrank start here, so either one
                // held low swallows the start edge.
                if (clearn && stopn && start_ok) begin
                    state_d = ST_COOK;
                    level_d = level_clamped;
                end
            end
            ST_COOK: begin
                if (!clearn) begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end else if (!door_closed || !stopn) begin
                    state_d = ST_PAUSED;
                end else if (timer_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSED: begin
                // A held stop button does not block resume.
                if (!clearn) begin
                    state_d = ST_IDLE;
                end else if (start_ok) begin
                    state_d = ST_COOK;
                    level_d = level_clamped;
                end
            end
            ST_DONE: begin
                if (!clearn || !door_closed) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cook_entry = (state_d == ST_COOK) && (state_q != ST_COOK);
    assign cook_hold  = (state_d == ST_COOK) && (state_q == ST_COOK);

    mag_duty_gen #(
        .N_LEVELS   (N_LEVELS),
        .SLOT_TICKS (SLOT_TICKS),
        .LEVEL_W    (LEVEL_W)
    ) u_duty (
        .clk     (clk),
        .reset   (reset),
        .clear   (cook_entry),
        .enable  (cook_hold),
        .level   (level_d),
        .on_next (duty_on)
    );

    assign mag_d = (state_d == ST_COOK) & duty_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            startn_q <= 1'b1;
            mag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            startn_q <= startn_d;
            mag_q    <= mag_d;
        end
    end

    // Door interlock is combinational so the drive drops in the same cycle.
    assign mag_on       = mag_q & door_closed;
    assign cooking      = (state_q == ST_COOK);
    assign paused       = (state_q == ST_PAUSED);
    assign done         = (state_q == ST_DONE);
    assign active_level = level_q;

endmodule

// File: tb/tb_mag_power_ctrl.sv
module tb_mag_power_ctrl;

    localparam int NL  = 4;
    localparam int ST  = 2;
    localparam int LW  = 4;
    localparam int PER = NL * ST;

    localparam int M_IDLE = 0, M_COOK = 1, M_PAUSED = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          startn, stopn, clearn, door_closed, timer_done;
    logic [LW-1:0] power_level;
    logic          mag_on, cooking, paused, done;
    logic [LW-1:0] active_level;

    int n_vec = 0;
    int n_err = 0;

    // reference model: state name, latched level, cycles since COOK entry
    int m_state, m_level, m_phase, m_mag, m_startn_prev;

    mag_power_ctrl #(.N_LEVELS(NL), .SLOT_TICKS(ST), .LEVEL_W(LW)) dut (
        .clk(clk), .reset(reset), .startn(startn), .stopn(stopn),
        .clearn(clearn), .door_closed(door_closed), .timer_done(timer_done),
        .power_level(power_level), .mag_on(mag_on), .cooking(cooking),
        .paused(paused), .done(done), .active_level(active_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_level = 0; m_phase = 0; m_mag = 0; m_startn_prev = 1;
    endtask

    task automatic check_all();
        check("mag_on",       32'(mag_on),       32'(m_mag & int'(door_closed)));
        check("cooking",      32'(cooking),      32'(m_state == M_COOK));
        check("paused",       32'(paused),       32'(m_state == M_PAUSED));
        check("done",         32'(done),         32'(m_state == M_DONE));
        check("active_level", 32'(active_level), 32'(m_level));
    endtask

    // One clock: inputs already set after a falling edge.
    task automatic cyc();
        int ns, sok, pl;
        #1;
        check("interlock", 32'(mag_on), 32'(m_mag & int'(door_closed)));
        pl  = int'(power_level);
        sok = (m_startn_prev == 1 && startn == 0 && door_closed && !timer_done && pl != 0);
        ns  = m_state;
        case (m_state)
            M_IDLE:   if (clearn && stopn && sok) ns = M_COOK;
            M_COOK: begin
                if (!clearn) begin ns = M_IDLE; m_level = 0; end
                else if (!door_closed || !stopn) ns = M_PAUSED;
                else if (timer_done) ns = M_DONE;
            end
            M_PAUSED: if (!clearn) ns = M_IDLE; else if (sok) ns = M_COOK;
            default:  if (!clearn || !door_closed) ns = M_IDLE;
        endcase
        if (ns == M_COOK && m_state != M_COOK) begin
            m_phase = 0;
            m_level = (pl > NL) ? NL : pl;
        end else if (ns == M_COOK) begin
            m_phase++;
        end
        m_mag = (ns == M_COOK) && (((m_phase % PER) / ST) < m_level);
        m_state = ns;
        m_startn_prev = int'(startn);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        startn = 1; stopn = 1; clearn = 1; door_closed = 1; timer_done = 0; power_level = '0;
    endtask

    task automatic press_start(input int lvl);
        power_level = LW'(lvl); startn = 0; cyc(); startn = 1; cyc();
    endtask

    task automatic do_reset();
        reset = 1; model_reset();
        @(negedge clk); @(negedge clk);
        reset = 0;
        #1 check_all();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        model_reset();
        #1;
        check("rst_mag_on", 32'(mag_on), 0);
        check("rst_active", 32'(active_level), 0);
        do_reset();

        // level 2: 1,1,1,1,0,0,0,0 from the entry edge
        power_level = 2; startn = 0; cyc();
        check("cook_entry", 32'(cooking), 1);
        check("lvl2_active", 32'(active_level), 2);
        startn = 1;
        for (int i = 0; i < 16; i++) begin
            check("lvl2_pattern", 32'(mag_on), 32'((i % 8) < 4));
            cyc();
        end

        // level 4 then door opens mid-slot
        clearn = 0; cyc(); clearn = 1; cyc();
        check("clear_level", 32'(active_level), 0);
        press_start(4); cyc(); cyc();
        door_closed = 0; #1;
        check("door_same_cycle", 32'(mag_on), 0);
        cyc();
        check("door_paused", 32'(paused), 1);
        door_closed = 1; cyc();
        startn = 0; cyc();
        check("resume_mag", 32'(mag_on), 1);
        check("resume_cook", 32'(cooking), 1);
        startn = 1; cyc();

        // rejected starts from IDLE
        clearn = 0; cyc(); clearn = 1; cyc();
        door_closed = 0; press_start(3); door_closed = 1; cyc();
        check("rej_door", 32'(cooking), 0);
        press_start(0);
        check("rej_zero", 32'(cooking), 0);
        timer_done = 1; press_start(3); timer_done = 0; cyc();
        check("rej_timer", 32'(cooking), 0);
        check("rej_level", 32'(active_level), 0);
        stopn = 0; press_start(3); stopn = 1; cyc();
        check("rej_stop", 32'(cooking), 0);

        // stop pause, clamped resume
        press_start(1); cyc();
        stopn = 0; cyc(); stopn = 1;
        check("stop_paused", 32'(paused), 1);
        check("stop_mag", 32'(mag_on), 0);
        press_start(6);
        check("clamp_level", 32'(active_level), 4);
        for (int i = 0; i < 10; i++) begin
            check("full_on", 32'(mag_on), 1);
            cyc();
        end

        // timer done, start ignored, door -> IDLE
        timer_done = 1; cyc(); timer_done = 0;
        check("done_flag", 32'(done), 1);
        check("done_mag", 32'(mag_on), 0);
        press_start(2);
        check("done_ignore", 32'(done), 1);
        door_closed = 0; cyc(); door_closed = 1; cyc();
        check("done_door_idle", 32'(cooking | paused | done), 0);
        press_start(3);
        clearn = 0; cyc(); clearn = 1;
        check("clear_cook", 32'(active_level), 0);

        // async reset mid-COOK
        press_start(4); cyc();
        check("pre_rst_mag", 32'(mag_on), 1);
        #2 reset = 1; #1;
        check("async_mag", 32'(mag_on), 0);
        check("async_cook", 32'(cooking), 0);
        check("async_lvl", 32'(active_level), 0);
        @(negedge clk);
        model_reset(); reset = 0; cyc();

        // held start: one accepted event only
        power_level = 3; startn = 0; cyc();
        stopn = 0; cyc(); stopn = 1;
        for (int i = 0; i < 20; i++) cyc();
        check("held_no_retrig", 32'(paused), 1);
        startn = 1; cyc();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            startn      = ($urandom_range(0, 3) != 0);
            stopn       = ($urandom_range(0, 19) != 0);
            clearn      = ($urandom_range(0, 49) != 0);
            door_closed = ($urandom_range(0, 14) != 0);
            timer_done  = ($urandom_range(0, 29) == 0);
            power_level = LW'($urandom_range(0, 7));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mag_power_ctrl.md
Name: mag_power_ctrl

Overview:
- Clocked, parametrised successor to the latch-style magnetron controller.
- Adds power levels through slot-based duty cycling, plus explicit IDLE/COOK/PAUSED/DONE states and a zero-latency door interlock.
- Sits between the front-panel button/door/timer inputs and the magnetron drive.
- Inputs: active-low startn/stopn/clearn, door_closed, timer_done, power_level.

Parameters:
- N_LEVELS, 10, number of duty slots per power period; maximum power level.
- SLOT_TICKS, 100, clock cycles per duty slot.
- LEVEL_W, 4, width of power_level; must satisfy 2**LEVEL_W > N_LEVELS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- startn  in  1  start button, active low; edge-detected.
- stopn  in  1  stop/pause button, active low; level-sensitive.
- clearn  in  1  clear button, active low; level-sensitive.
- door_closed  in  1  1 = door closed.
- timer_done  in  1  1 = cook timer expired.
- power_level  in  LEVEL_W  requested level; sampled only when start is accepted.
- mag_on  out  1  magnetron drive.
- cooking  out  1  state == COOK.
- paused  out  1  state == PAUSED.
- done  out  1  state == DONE.
- active_level  out  LEVEL_W  latched level in use.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; mag_q=0; active_level=0; tick=0; slot=0.
  - startn_q=1; all outputs 0.
- start_edge = startn_q & ~startn; startn_q <= startn every clock.
- start_ok = start_edge & door_closed & ~timer_done & (power_level != 0).
- Level clamp: on start_ok, active_level <= min(power_level, N_LEVELS).
- Events are evaluated once per edge. Priority, highest first: clearn low, door open, stopn low, timer_done, start_ok.
- IDLE:
  - start_ok -> COOK; tick=0, slot=0.
  - Otherwise stay.
- COOK:
  - clearn=0 -> IDLE, and active_level=0.
  - door_closed=0 -> PAUSED.
  - stopn=0 -> PAUSED.
  - timer_done=1 -> DONE.
  - Otherwise stay and advance the duty counters.
- Duty counters (advance only in COOK):
  - tick increments each clock; at SLOT_TICKS-1, tick wraps to 0 and slot increments.
  - slot wraps from N_LEVELS-1 to 0.
  - Counters hold in PAUSED/DONE and reset to 0 on every COOK entry.
- PAUSED:
  - clearn=0 -> IDLE.
  - start_ok -> COOK; new power_level is latched and counters restart at 0.
  - stopn held low does not block resume; only the start edge matters.
- DONE:
  - clearn=0 -> IDLE.
  - door_closed=0 -> IDLE.
  - start is ignored.
- mag_q is a register loaded each edge with (state_next==COOK) & (slot_next < active_level_next).
  - Duty = active_level/N_LEVELS; level N_LEVELS gives a continuous on.
  - The first on-cycle coincides with the COOK entry edge.
- mag_on = mag_q & door_closed (combinational interlock): mag_on is 0 in the same cycle the door opens.
- cooking/paused/done are decoded from the state register. Only mag_on has a combinational path from an input.
- Simultaneous start edge and stopn low in IDLE: stop has priority, so there is no transition, because stop is not an IDLE exit and start_ok is masked.
  - Rule: start_ok is accepted only if stopn=1 and clearn=1.
- reset mid-COOK: mag_on drops immediately (async).
- A start edge while startn stays low produces one event only; holding the button does not retrigger.

Decomposition:
- Package mag_pkg:
  - state encoding IDLE=2'd0, COOK=2'd1, PAUSED=2'd2, DONE=2'd3.
  - default N_LEVELS/SLOT_TICKS constants.
- Sub-module mag_duty_gen:
  - contains tick/slot counters plus compare.
  - inputs: clk, reset, clear, enable, level.
  - output: on_next.
  - used for COOK duty only.
- Main FSM plus start edge detect stays in mag_power_ctrl.

Test Plan (N_LEVELS=4, SLOT_TICKS=2, so an 8-clock period):
- Reset, then start edge, power_level=2, door closed -> cooking=1, active_level=2; mag_on pattern 1,1,1,1,0,0,0,0 repeating from the entry edge.
- Cooking at level 4, then door_closed=0 mid-slot -> mag_on=0 the same cycle, paused=1 at next edge; door closes, then start edge -> COOK, counters restart, mag_on=1.
- Start edge with door open, with power_level=0, and with timer_done=1 (three separate tries) -> state stays IDLE, mag_on=0, active_level=0.
- COOK, then stopn low 1 cycle -> PAUSED, mag_on=0; start edge with power_level=6 -> active_level=4 (clamped), mag_on continuous.
- COOK, then timer_done=1 -> done=1, mag_on=0; start edge ignored; door opens -> IDLE; clearn low in COOK -> IDLE, active_level=0.
- Assert reset mid-COOK while mag_on=1 -> mag_on and all outputs 0 without a clock edge; startn held low 20 clocks after a start -> only one accepted start.
